dac_jesd204_chan_src: RTL and testbench

DAC_JESD204_CHAN_SRC -- requirements
Module: dac_jesd204_chan_src

---
 rtl/dac_jesd204_chan_src.sv | 122 ++++++++++++
 tb/tb_dac_jesd204_chan_src.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dac_jesd204_chan_src.sv
// dac_jesd204_chan_src: per-channel DAC sample source (DMA, constant, PN7/PN15, ramp) feeding a JESD204 link.
// Rev 1.0
`default_nettype none

module dac_jesd204_chan_src #(
  parameter int DATA_PATH_WIDTH = 4,
  parameter int CHANNEL_WIDTH   = 14,
  parameter int TWOS_COMPLEMENT = 1
) (
  input  logic                                     dac_clk,
  input  logic                                     dac_rst,
  input  logic                                     dac_enable,
  input  logic [2:0]                               dac_data_sel,
  input  logic [15:0]                              dac_pat_data,
  input  logic [DATA_PATH_WIDTH*16-1:0]            dac_dma_data,
  input  logic                                     dac_dma_valid,
  output logic                                     dac_dma_ready,
  output logic                                     dac_dma_unf,
  output logic [DATA_PATH_WIDTH*CHANNEL_WIDTH-1:0] dac_if_data
);

  localparam int         C_SMP_BITS = DATA_PATH_WIDTH * 16;
  localparam logic [2:0] C_SEL_DMA  = 3'd0;
  localparam logic [2:0] C_SEL_PAT  = 3'd1;
  localparam logic [2:0] C_SEL_PN7  = 3'd2;
  localparam logic [2:0] C_SEL_PN15 = 3'd3;
  localparam logic [2:0] C_SEL_RAMP = 3'd4;

  logic [2:0]                               sel_q;
  logic [14:0]                              lfsr_q, lfsr_d, lfsr_cur, lfsr_adv;
  logic [15:0]                              ramp_q, ramp_d, ramp_cur;
  logic [DATA_PATH_WIDTH*CHANNEL_WIDTH-1:0] data_q, data_d;
  logic                                     unf_q, unf_d;
  logic [C_SMP_BITS-1:0]                    pn_bits;
  logic [C_SMP_BITS-1:0]                    smp;
  logic                                     sel_chg;

  function automatic logic [CHANNEL_WIDTH-1:0] fmt(input logic [15:0] s);
    logic [15:0] t;
    t = (TWOS_COMPLEMENT != 0) ? s : (s ^ 16'h8000);
    return t[15 -: CHANNEL_WIDTH];
  endfunction

  assign dac_dma_ready = dac_enable && (dac_data_sel == C_SEL_DMA);
  assign dac_dma_unf   = unf_q;
  assign dac_if_data   = data_q;

  // A new selection takes effect immediately, so the generators are seeded in the same cycle.
  assign sel_chg  = (dac_data_sel != sel_q);
  assign lfsr_cur = sel_chg ? 15'h7FFF : lfsr_q;
  assign ramp_cur = sel_chg ? 16'h0000 : ramp_q;

  // The register holds the next N sequence bits, oldest at bit N-1; b[n] = b[n-1] ^ b[n-N].
  always_comb begin
    logic [14:0] s;
    logic        fb;
    s       = lfsr_cur;
    pn_bits = '0;
    for (int j = 0; j < DATA_PATH_WIDTH; j++) begin
      for (int t = 0; t < 16; t++) begin
        if (dac_data_sel == C_SEL_PN15) begin
          pn_bits[j*16 + 15 - t] = s[14];
          fb = s[14] ^ s[0];
        end else begin
          pn_bits[j*16 + 15 - t] = s[6];
          fb = s[6] ^ s[0];
        end
        s = {s[13:0], fb};
      end
    end
    lfsr_adv = s;
  end

  always_comb begin
    smp    = '0;
    unf_d  = 1'b0;
    lfsr_d = 15'h7FFF;
    ramp_d = 16'h0000;
    if (dac_enable) begin
      case (dac_data_sel)
        C_SEL_DMA: begin
          if (dac_dma_valid) smp = dac_dma_data;
          else               unf_d = 1'b1;
        end
        C_SEL_PAT: begin
          for (int j = 0; j < DATA_PATH_WIDTH; j++) smp[j*16 +: 16] = dac_pat_data;
        end
        C_SEL_PN7, C_SEL_PN15: begin
          smp    = pn_bits;
          lfsr_d = lfsr_adv;
        end
        C_SEL_RAMP: begin
          for (int j = 0; j < DATA_PATH_WIDTH; j++) smp[j*16 +: 16] = ramp_cur + 16'(j);
          ramp_d = ramp_cur + 16'(DATA_PATH_WIDTH);
        end
        default: ;
      endcase
    end
    for (int j = 0; j < DATA_PATH_WIDTH; j++) begin
      data_d[j*CHANNEL_WIDTH +: CHANNEL_WIDTH] = fmt(smp[j*16 +: 16]);
    end
  end

  always_ff @(posedge dac_clk or posedge dac_rst) begin
    if (dac_rst) begin
      sel_q  <= 3'd0;
      lfsr_q <= 15'h7FFF;
      ramp_q <= 16'h0000;
      unf_q  <= 1'b0;
      data_q <= {DATA_PATH_WIDTH{fmt(16'h0000)}};
    end else begin
      sel_q  <= dac_data_sel;
      lfsr_q <= lfsr_d;
      ramp_q <= ramp_d;
      unf_q  <= unf_d;
      data_q <= data_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dac_jesd204_chan_src.sv
// Testbench for dac_jesd204_chan_src: two instances (CW=16 two's complement, CW=14 offset binary)
// driven in parallel and compared against a bit-serial behavioural model.
`default_nettype none

module tb_dac_jesd204_chan_src;

  logic        dac_clk = 1'b0;
  logic        dac_rst;
  logic        en;
  logic [2:0]  sel;
  logic [15:0] pat;
  logic [63:0] dma;
  logic        valid;
  logic        rdy1, rdy2, unf1, unf2;
  logic [63:0] data1;
  logic [55:0] data2;

  int checks   = 0;
  int failures = 0;

  bit pn7  [127];
  bit pn15 [32767];

  int          m_r, m_ptr, m_prev_sel;
  logic [15:0] es [4];
  logic        e_unf;

  always #5 dac_clk = ~dac_clk;

  dac_jesd204_chan_src #(.DATA_PATH_WIDTH(4), .CHANNEL_WIDTH(16), .TWOS_COMPLEMENT(1)) u_dut1 (
    .dac_clk(dac_clk), .dac_rst(dac_rst), .dac_enable(en), .dac_data_sel(sel),
    .dac_pat_data(pat), .dac_dma_data(dma), .dac_dma_valid(valid),
    .dac_dma_ready(rdy1), .dac_dma_unf(unf1), .dac_if_data(data1));

  dac_jesd204_chan_src #(.DATA_PATH_WIDTH(4), .CHANNEL_WIDTH(14), .TWOS_COMPLEMENT(0)) u_dut2 (
    .dac_clk(dac_clk), .dac_rst(dac_rst), .dac_enable(en), .dac_data_sel(sel),
    .dac_pat_data(pat), .dac_dma_data(dma), .dac_dma_valid(valid),
    .dac_dma_ready(rdy2), .dac_dma_unf(unf2), .dac_if_data(data2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pnword(input int n, input int idx);
    logic [15:0] w;
    for (int t = 0; t < 16; t++)
      w[15-t] = (n == 7) ? pn7[(idx + t) % 127] : pn15[(idx + t) % 32767];
    return w;
  endfunction

  task automatic model_reset();
    m_r = 0; m_ptr = 0; e_unf = 1'b0;
    for (int j = 0; j < 4; j++) es[j] = 16'h0000;
  endtask

  // Expected output after the next clock edge, from the current inputs.
  task automatic model_step();
    if (int'(sel) != m_prev_sel) begin m_r = 0; m_ptr = 0; end
    m_prev_sel = int'(sel);
    e_unf = 1'b0;
    for (int j = 0; j < 4; j++) es[j] = 16'h0000;
    if (!en) begin
      m_r = 0; m_ptr = 0;
    end else begin
      case (sel)
        3'd0: begin
          if (valid) for (int j = 0; j < 4; j++) es[j] = dma[j*16 +: 16];
          else e_unf = 1'b1;
          m_r = 0; m_ptr = 0;
        end
        3'd1: begin
          for (int j = 0; j < 4; j++) es[j] = pat;
          m_r = 0; m_ptr = 0;
        end
        3'd2: begin
          for (int j = 0; j < 4; j++) es[j] = pnword(7, m_ptr + 16*j);
          m_ptr = (m_ptr + 64) % 127; m_r = 0;
        end
        3'd3: begin
          for (int j = 0; j < 4; j++) es[j] = pnword(15, m_ptr + 16*j);
          m_ptr = (m_ptr + 64) % 32767; m_r = 0;
        end
        3'd4: begin
          for (int j = 0; j < 4; j++) es[j] = 16'((m_r + j) % 65536);
          m_r = (m_r + 4) % 65536; m_ptr = 0;
        end
        default: begin m_r = 0; m_ptr = 0; end
      endcase
    end
  endtask

  task automatic compare();
    logic [63:0] e1, e2;
    logic [15:0] ob;
    e2 = '0;
    e1 = {es[3], es[2], es[1], es[0]};
    for (int j = 0; j < 4; j++) begin
      ob = es[j] ^ 16'h8000;
      e2[j*14 +: 14] = ob[15:2];
    end
    chk("data_cw16", data1, e1);
    chk("data_cw14", {8'h00, data2}, e2);
    chk("unf_cw16", {63'd0, unf1}, {63'd0, e_unf});
    chk("unf_cw14", {63'd0, unf2}, {63'd0, e_unf});
  endtask

  task automatic cyc();
    #1;
    chk("ready", {62'd0, rdy2, rdy1}, {62'd0, {2{en && (sel == 3'd0)}}});
    model_step();
    @(posedge dac_clk);
    #1;
    compare();
  endtask

  initial begin
    int hold;
    for (int i = 0; i < 127; i++)   pn7[i]  = (i < 7)  ? 1'b1 : (pn7[i-1] ^ pn7[i-7]);
    for (int i = 0; i < 32767; i++) pn15[i] = (i < 15) ? 1'b1 : (pn15[i-1] ^ pn15[i-15]);
    m_prev_sel = -1;
    model_reset();

    dac_rst = 1'b1; en = 1'b0; sel = 3'd0; pat = 16'h0; dma = '0; valid = 1'b0;
    repeat (2) @(posedge dac_clk);
    #1;
    chk("rst_data_cw16", data1, 64'h0);
    chk("rst_data_cw14", {8'h00, data2}, {8'h00, {4{14'h2000}}});
    chk("rst_unf", {62'd0, unf2, unf1}, 64'd0);
    dac_rst = 1'b0;

    // Ramp from seed, then run to the wrap point.
    en = 1'b1; sel = 3'd4;
    cyc();
    chk("ramp_first", data1, {16'd3, 16'd2, 16'd1, 16'd0});
    cyc();
    chk("ramp_second", data1, {16'd7, 16'd6, 16'd5, 16'd4});
    while (m_r != 16'hFFFC) cyc();
    cyc();
    chk("ramp_top", data1, {16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC});
    cyc();
    chk("ramp_wrap", data1, {16'd3, 16'd2, 16'd1, 16'd0});
    repeat (5) cyc();

    // Asynchronous reset between edges.
    #2 dac_rst = 1'b1;
    #1;
    chk("arst_data_cw16", data1, 64'h0);
    chk("arst_data_cw14", {8'h00, data2}, {8'h00, {4{14'h2000}}});
    chk("arst_unf", {62'd0, unf2, unf1}, 64'd0);
    model_reset();
    @(posedge dac_clk);
    #3 dac_rst = 1'b0;
    cyc();
    chk("ramp_after_rst", data1, {16'd3, 16'd2, 16'd1, 16'd0});

    // DMA with a gap.
    sel = 3'd0; valid = 1'b1; dma = 64'h1111_2222_3333_4444;
    cyc();
    chk("dma_A", data1, 64'h1111_2222_3333_4444);
    valid = 1'b0; dma = 64'hDEAD_BEEF_DEAD_BEEF;
    cyc();
    chk("dma_gap", data1, 64'h0);
    chk("dma_gap_unf", {63'd0, unf1}, 64'd1);
    valid = 1'b1; dma = 64'h8000_7FFF_0001_FFFF;
    cyc();
    chk("dma_B", data1, 64'h8000_7FFF_0001_FFFF);
    chk("dma_B_unf", {63'd0, unf1}, 64'd0);

    // Formatting on the offset-binary 14-bit instance.
    sel = 3'd1; pat = 16'h8000;
    cyc();
    chk("fmt_8000", {8'h00, data2}, 64'h0);
    pat = 16'h7FFF;
    cyc();
    chk("fmt_7FFF", {8'h00, data2}, {8'h00, {4{14'h3FFF}}});

    // PN7 and PN15 long runs.
    sel = 3'd2;
    cyc();
    chk("pn7_first", {48'd0, data1[15:0]}, 64'hFEA9);
    for (int c = 0; c < 999; c++) begin valid = 1'($urandom); pat = 16'($urandom); cyc(); end
    sel = 3'd3;
    cyc();
    chk("pn15_first", {48'd0, data1[15:0]}, 64'hFFFE);
    for (int c = 0; c < 999; c++) begin valid = 1'($urandom); cyc(); end

    // PN15 -> ramp -> PN15.
    sel = 3'd4;
    cyc();
    chk("sw_ramp", data1, {16'd3, 16'd2, 16'd1, 16'd0});
    repeat (3) cyc();
    sel = 3'd3;
    cyc();
    chk("sw_pn15", {48'd0, data1[15:0]}, 64'hFFFE);
    repeat (3) cyc();

    // Randomized mode / enable / DMA traffic.
    for (int k = 0; k < 60; k++) begin
      sel  = 3'($urandom_range(0, 7));
      en   = ($urandom_range(0, 9) != 0);
      hold = $urandom_range(1, 20);
      for (int c = 0; c < hold; c++) begin
        valid = 1'($urandom);
        pat   = 16'($urandom);
        dma   = {$urandom, $urandom};
        if ($urandom_range(0, 15) == 0) en = ~en;
        cyc();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
